// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for branch flush, load-use stall, memory wait and halt/drain.
module pipe_hazard_ctrl #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int REG_ADDR_W       = 4,
  parameter int FLUSH_CYCLES     = 2,
  parameter int LOAD_LAT         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        branch_taken,
  input  logic [MEMORY_ADDR_SIZE-1:0] jaddr_in,
  input  logic                        exe_rd_mem_en,
  input  logic [REG_ADDR_W-1:0]       exe_dst,
  input  logic [REG_ADDR_W-1:0]       id_src1,
  input  logic [REG_ADDR_W-1:0]       id_src2,
  input  logic [1:0]                  id_src_vld,
  input  logic                        mem_busy,
  input  logic                        halt_req,
  output logic                        pc_en,
  output logic                        redirect,
  output logic [MEMORY_ADDR_SIZE-1:0] redirect_addr,
  output logic                        ifid_stop,
  output logic                        idexe_stop,
  output logic                        exemem_stop,
  output logic                        ifid_flush,
  output logic                        idexe_flush,
  output logic                        halted,
  output logic [ARQ-1:0]              stall_cnt,
  output logic [2:0]                  state
);
  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam int MX = FLUSH_CYCLES > LOAD_LAT ? FLUSH_CYCLES : LOAD_LAT;
  localparam int CW = $clog2(MX + 1);
  logic [2:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        pend_q, pend_d;
  logic [MEMORY_ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
  logic [ARQ-1:0]              stall_cnt_q, stall_cnt_d;
  logic                        luh;
  assign luh = exe_rd_mem_en && ((id_src_vld[0] && id_src1 == exe_dst) ||
                                 (id_src_vld[1] && id_src2 == exe_dst));
  assign state = state_q;
  assign stall_cnt = stall_cnt_q;
  always_comb begin
    pc_en = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    ifid_stop = 1'b0;
    idexe_stop = 1'b0;
    exemem_stop = 1'b0;
    ifid_flush = 1'b0;
    idexe_flush = 1'b0;
    halted = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    pend_addr_d = pend_addr_q;
    if (state_q == S_HALT) begin
      ifid_flush = 1'b1;
      halted = 1'b1;
      if (!halt_req) begin
        redirect = pend_q;
        redirect_addr = pend_addr_q;
        pend_d = 1'b0;
        pend_addr_d = '0;
        state_d = S_RUN;
      end else if (branch_taken) begin
        pend_d = 1'b1;
        pend_addr_d = jaddr_in;
      end
    end else if (mem_busy && (state_q == S_FLUSH || state_q == S_LOAD || state_q == S_MEM)) begin
      {ifid_stop, idexe_stop, exemem_stop} = 3'b111;
    end else if (state_q == S_FLUSH) begin
      pc_en = 1'b1;
      ifid_flush = 1'b1;
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? S_RUN : S_FLUSH;
    end else if (state_q == S_LOAD) begin
      ifid_stop = 1'b1;
      idexe_flush = 1'b1;
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? S_RUN : S_LOAD;
    end else if (branch_taken) begin
      // RUN evaluation; also the first non-busy cycle of MEM_WAIT
      pc_en = 1'b1;
      redirect = 1'b1;
      redirect_addr = jaddr_in;
      ifid_flush = 1'b1;
      idexe_flush = 1'b1;
      cnt_d = CW'(FLUSH_CYCLES - 1);
      state_d = FLUSH_CYCLES > 1 ? S_FLUSH : S_RUN;
    end else if (mem_busy) begin
      {ifid_stop, idexe_stop, exemem_stop} = 3'b111;
      state_d = S_MEM;
    end else if (luh) begin
      ifid_stop = 1'b1;
      idexe_flush = 1'b1;
      cnt_d = CW'(LOAD_LAT - 1);
      state_d = LOAD_LAT > 1 ? S_LOAD : S_RUN;
    end else if (halt_req) begin
      ifid_flush = 1'b1;
      state_d = S_HALT;
    end else begin
      pc_en = 1'b1;
      state_d = S_RUN;
    end
    stall_cnt_d = (!pc_en && ~&stall_cnt_q) ? stall_cnt_q + ARQ'(1) : stall_cnt_q;
    if (!rst) begin
      pc_en = 1'b0;
      redirect = 1'b0;
      redirect_addr = '0;
      {ifid_stop, idexe_stop, exemem_stop} = 3'b000;
      ifid_flush = 1'b1;
      idexe_flush = 1'b1;
      halted = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q <= '0;
      pend_q <= 1'b0;
      pend_addr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      pend_addr_q <= pend_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus randomized checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int FC = 2, LL = 1, MA = 13, RW = 4, ARQ = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, branch_taken, exe_rd_mem_en, mem_busy, halt_req;
  logic [MA-1:0] jaddr_in;
  logic [RW-1:0] exe_dst, id_src1, id_src2;
  logic [1:0] id_src_vld;
  logic pc_en, redirect, ifid_stop, idexe_stop, exemem_stop, ifid_flush, idexe_flush, halted;
  logic [MA-1:0] redirect_addr;
  logic [ARQ-1:0] stall_cnt;
  logic [2:0] state;
  int tests = 0, fails = 0;
  int m_mode, m_left, m_stall, m_paddr;
  bit m_pend;
  bit hr;

  pipe_hazard_ctrl #(.ARQ(ARQ), .MEMORY_ADDR_SIZE(MA), .REG_ADDR_W(RW),
                     .FLUSH_CYCLES(FC), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .jaddr_in(jaddr_in),
    .exe_rd_mem_en(exe_rd_mem_en), .exe_dst(exe_dst), .id_src1(id_src1), .id_src2(id_src2),
    .id_src_vld(id_src_vld), .mem_busy(mem_busy), .halt_req(halt_req), .pc_en(pc_en),
    .redirect(redirect), .redirect_addr(redirect_addr), .ifid_stop(ifid_stop),
    .idexe_stop(idexe_stop), .exemem_stop(exemem_stop), .ifid_flush(ifid_flush),
    .idexe_flush(idexe_flush), .halted(halted), .stall_cnt(stall_cnt), .state(state));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic clr();
    branch_taken = 0; jaddr_in = '0; exe_rd_mem_en = 0; exe_dst = '0;
    id_src1 = '0; id_src2 = '0; id_src_vld = '0; mem_busy = 0; halt_req = 0;
  endtask

  task automatic nx();
    @(negedge clk);
    clr();
  endtask

  task automatic mreset();
    m_mode = 0; m_left = 0; m_stall = 0; m_pend = 0; m_paddr = 0;
  endtask

  task automatic chk_reset();
    chk("rst_pc_en", pc_en, 0); chk("rst_ifid_flush", ifid_flush, 1);
    chk("rst_idexe_flush", idexe_flush, 1); chk("rst_redirect", redirect, 0);
    chk("rst_redirect_addr", redirect_addr, 0);
    chk("rst_stops", {ifid_stop, idexe_stop, exemem_stop}, 0);
    chk("rst_halted", halted, 0); chk("rst_state", state, 0); chk("rst_stall_cnt", stall_cnt, 0);
  endtask

  // Model: expected outputs this cycle from the mode and inputs, then advance the mode.
  task automatic go();
    int st, sc, e_raddr;
    bit e_pc, e_red, e_ifs, e_ids, e_ems, e_iff, e_idf, e_hlt, luh;
    #2;
    st = m_mode; sc = m_stall;
    {e_pc, e_red, e_ifs, e_ids, e_ems, e_iff, e_idf, e_hlt} = '0;
    e_raddr = 0;
    luh = exe_rd_mem_en && ((id_src_vld[0] && id_src1 == exe_dst) ||
                            (id_src_vld[1] && id_src2 == exe_dst));
    if (m_mode == 4) begin
      e_iff = 1; e_hlt = 1;
      if (!halt_req) begin
        e_red = m_pend; e_raddr = m_paddr; m_pend = 0; m_paddr = 0; m_mode = 0;
      end else if (branch_taken) begin
        m_pend = 1; m_paddr = int'(jaddr_in);
      end
    end else if (mem_busy && m_mode inside {1, 2, 3}) begin
      {e_ifs, e_ids, e_ems} = 3'b111;
    end else if (m_mode == 1) begin
      e_pc = 1; e_iff = 1; m_left--;
      if (m_left == 0) m_mode = 0;
    end else if (m_mode == 2) begin
      e_ifs = 1; e_idf = 1; m_left--;
      if (m_left == 0) m_mode = 0;
    end else if (branch_taken) begin
      e_pc = 1; e_red = 1; e_raddr = int'(jaddr_in); e_iff = 1; e_idf = 1;
      m_left = FC - 1; m_mode = m_left > 0 ? 1 : 0;
    end else if (mem_busy) begin
      {e_ifs, e_ids, e_ems} = 3'b111; m_mode = 3;
    end else if (luh) begin
      e_ifs = 1; e_idf = 1; m_left = LL - 1; m_mode = m_left > 0 ? 2 : 0;
    end else if (halt_req) begin
      e_iff = 1; m_mode = 4;
    end else begin
      e_pc = 1; m_mode = 0;
    end
    chk("pc_en", pc_en, e_pc); chk("redirect", redirect, e_red);
    chk("redirect_addr", redirect_addr, e_raddr); chk("ifid_stop", ifid_stop, e_ifs);
    chk("idexe_stop", idexe_stop, e_ids); chk("exemem_stop", exemem_stop, e_ems);
    chk("ifid_flush", ifid_flush, e_iff); chk("idexe_flush", idexe_flush, e_idf);
    chk("halted", halted, e_hlt); chk("state", state, st); chk("stall_cnt", stall_cnt, sc);
    if (!e_pc && m_stall < (1 << ARQ) - 1) m_stall++;
  endtask

  initial begin
    rst = 0; clr(); mreset(); hr = 0;
    #1 chk_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nx();
      go();
      chk("idle_pc_en", pc_en, 1); chk("idle_state", state, 0); chk("idle_stall", stall_cnt, 0);
    end
    nx(); branch_taken = 1; jaddr_in = 13'd1112; go();
    chk("br_redirect", redirect, 1); chk("br_addr", redirect_addr, 1112);
    chk("br_flushes", {ifid_flush, idexe_flush}, 2'b11);
    nx(); go();
    chk("br_fl2", {ifid_flush, idexe_flush, redirect}, 3'b100); chk("br_fl2_state", state, 1);
    nx(); go(); chk("br_back_run", state, 0);
    nx(); exe_rd_mem_en = 1; exe_dst = 3; id_src2 = 3; id_src_vld = 2'b10; go();
    chk("lu_pc_en", pc_en, 0); chk("lu_ifid_stop", ifid_stop, 1); chk("lu_idexe_flush", idexe_flush, 1);
    nx(); exe_rd_mem_en = 1; exe_dst = 3; id_src2 = 3; id_src_vld = 2'b00; go();
    chk("lu_stall_cnt", stall_cnt, 1); chk("lu_novld_pc_en", pc_en, 1);
    for (int i = 0; i < 3; i++) begin
      nx(); mem_busy = 1; go();
      chk("mb_stops", {pc_en, ifid_stop, idexe_stop, exemem_stop}, 4'b0111);
    end
    nx(); go(); chk("mb_exit_pc_en", pc_en, 1); chk("mb_stall_cnt", stall_cnt, 4);
    nx(); branch_taken = 1; mem_busy = 1; jaddr_in = 13'd77; go();
    chk("brmb_redirect", redirect, 1); chk("brmb_pc_en", pc_en, 1);
    nx(); mem_busy = 1; go(); chk("brmb_flush_wait", state, 1);
    nx(); go(); chk("brmb_flush", ifid_flush, 1);
    nx(); go();
    for (int i = 0; i < 5; i++) begin
      nx(); halt_req = 1;
      if (i == 2) begin branch_taken = 1; jaddr_in = 13'd40; end
      go();
      if (i > 0) chk("halt_halted", halted, 1);
    end
    nx(); go(); chk("halt_exit_redirect", redirect, 1); chk("halt_exit_addr", redirect_addr, 40);
    nx(); go(); chk("halt_after_redirect", redirect, 0); chk("halt_after_state", state, 0);
    nx(); branch_taken = 1; jaddr_in = 13'd500; go();
    nx(); #2 chk("midflush_state", state, 1);
    rst = 0; #1 chk_reset(); mreset();
    nx(); rst = 1; go(); chk("postflush_redirect", redirect, 0); chk("postflush_pc_en", pc_en, 1);
    nx(); halt_req = 1; go();
    nx(); halt_req = 1; branch_taken = 1; jaddr_in = 13'd99; go();
    nx(); halt_req = 1; #2 chk("midhalt_halted", halted, 1);
    rst = 0; #1 chk_reset(); mreset();
    nx(); rst = 1; go(); chk("posthalt_redirect", redirect, 0);
    for (int i = 0; i < 3000; i++) begin
      nx();
      rst = 1;
      if ($urandom_range(0, 15) == 0) hr = ~hr;
      halt_req = hr;
      branch_taken = $urandom_range(0, 5) == 0;
      jaddr_in = MA'($urandom);
      mem_busy = $urandom_range(0, 5) == 0;
      exe_rd_mem_en = $urandom_range(0, 2) == 0;
      exe_dst = RW'($urandom_range(0, 3));
      id_src1 = RW'($urandom_range(0, 3));
      id_src2 = RW'($urandom_range(0, 3));
      id_src_vld = 2'($urandom);
      go();
      if ($urandom_range(0, 99) == 0) begin
        rst = 0; #1 chk_reset(); mreset();
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
